// File: rtl/cnt_seq_mon_pkg.sv
// -----------------------------------------------------------------------------
// cnt_seq_mon_pkg
// Shared definitions for the counter sequence monitor:
//   - mon_state_e : tracking FSM states (UNLOCKED, ACQUIRE, LOCKED)
//   - ERR_CNT_W   : width of the error tally
// -----------------------------------------------------------------------------
package cnt_seq_mon_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } mon_state_e;

    localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter: increments on inc_i, holds at all-ones, never wraps.
// Synchronous clear has priority over increment.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset (count -> 0)
//   clr_i  : synchronous clear (count -> 0)
//   inc_i  : increment request
//   cnt_o  : current count (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cnt_seq_monitor.sv
// -----------------------------------------------------------------------------
// cnt_seq_monitor
// Watches the output of a free-running wrap counter (0..CNT_MAX) and checks
// that each valid sample is the legal successor of the previous one. After
// LOCK_CNT consecutive correct steps it asserts 'locked'; while locked it
// reports CNT_MAX->0 wraps and sequence errors with pulses and saturating
// tallies.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   cnt_in     : monitored count value (CNT_WIDTH bits)
//   cnt_vld    : cnt_in is sampled this cycle
//   clear      : synchronous clear of tallies and lock (drops same-cycle sample)
//   locked     : sequence is being tracked
//   wrap_pulse : one-cycle pulse per locked CNT_MAX->0 transition
//   wrap_cnt   : saturating wrap tally (WRAP_WIDTH bits)
//   err_pulse  : one-cycle pulse per sequence error while locked
//   err_cnt    : saturating error tally (8 bits)
//
// Build option:
//   CNT_SEQ_MON_ERR_CNT_EN : when defined the error tally is built; otherwise
//                            err_cnt is constant 0 (err_pulse unaffected).
// -----------------------------------------------------------------------------
module cnt_seq_monitor
    import cnt_seq_mon_pkg::*;
#(
    parameter int unsigned CNT_WIDTH  = 8,
    parameter int unsigned CNT_MAX    = 11,
    parameter int unsigned LOCK_CNT   = 2,
    parameter int unsigned WRAP_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CNT_WIDTH-1:0]  cnt_in,
    input  logic                  cnt_vld,
    input  logic                  clear,
    output logic                  locked,
    output logic                  wrap_pulse,
    output logic [WRAP_WIDTH-1:0] wrap_cnt,
    output logic                  err_pulse,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    localparam int unsigned EXT_W  = CNT_WIDTH + 1;
    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam logic [EXT_W-1:0]  MAX_EXT  = EXT_W'(CNT_MAX);
    localparam logic [GOOD_W-1:0] LOCK_VAL = GOOD_W'(LOCK_CNT);

    mon_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0]  prev_q,  prev_d;
    logic [GOOD_W-1:0]     good_q,  good_d;
    logic                  wrap_pulse_q, wrap_pulse_d;
    logic                  err_pulse_q,  err_pulse_d;

    // Comparisons are done one bit wider so prev+1 never folds through
    // 2^CNT_WIDTH when CNT_MAX sits at the top of the range.
    logic [EXT_W-1:0] cnt_ext;
    logic [EXT_W-1:0] prev_ext;
    logic [EXT_W-1:0] exp_ext;
    logic             in_range;
    logic             match;

    assign cnt_ext  = {1'b0, cnt_in};
    assign prev_ext = {1'b0, prev_q};
    assign exp_ext  = (prev_ext < MAX_EXT) ? (prev_ext + EXT_W'(1)) : '0;
    assign in_range = (cnt_ext <= MAX_EXT);
    assign match    = (cnt_ext == exp_ext);

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        good_d       = good_q;
        wrap_pulse_d = 1'b0;
        err_pulse_d  = 1'b0;

        if (clear) begin
            state_d = UNLOCKED;
            good_d  = '0;
        end else if (cnt_vld) begin
            prev_d = cnt_in;
            case (state_q)
                UNLOCKED: begin
                    if (in_range) begin
                        state_d = ACQUIRE;
                        good_d  = '0;
                    end
                end
                ACQUIRE: begin
                    if (!in_range) begin
                        state_d = UNLOCKED;
                        good_d  = '0;
                    end else if (match) begin
                        good_d = good_q + GOOD_W'(1);
                        if ((good_q + GOOD_W'(1)) == LOCK_VAL) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        // A match after CNT_MAX can only be 0, so this is the wrap.
                        wrap_pulse_d = (prev_ext == MAX_EXT);
                    end else begin
                        err_pulse_d = 1'b1;
                        good_d      = '0;
                        state_d     = in_range ? ACQUIRE : UNLOCKED;
                    end
                end
                default: begin
                    state_d = UNLOCKED;
                    good_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= UNLOCKED;
            prev_q       <= '0;
            good_q       <= '0;
            wrap_pulse_q <= 1'b0;
            err_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            good_q       <= good_d;
            wrap_pulse_q <= wrap_pulse_d;
            err_pulse_q  <= err_pulse_d;
        end
    end

    assign locked     = (state_q == LOCKED);
    assign wrap_pulse = wrap_pulse_q;
    assign err_pulse  = err_pulse_q;

    sat_counter #(
        .WIDTH (WRAP_WIDTH)
    ) u_wrap_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clear),
        .inc_i (wrap_pulse_d),
        .cnt_o (wrap_cnt)
    );

`ifdef CNT_SEQ_MON_ERR_CNT_EN
    sat_counter #(
        .WIDTH (ERR_CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clear),
        .inc_i (err_pulse_d),
        .cnt_o (err_cnt)
    );
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_cnt_seq_monitor.sv
// -----------------------------------------------------------------------------
// tb_cnt_seq_monitor
// Directed bench for cnt_seq_monitor (CNT_WIDTH=6, CNT_MAX=9, LOCK_CNT=2).
// Two instances share the stimulus: dut_a with a 16-bit wrap tally and dut_s
// with a 2-bit wrap tally for saturation. A behavioural model (anchor value +
// run length of consecutive correct steps) predicts every output and is
// compared each cycle; literal expectations pin key points of the sequence.
// -----------------------------------------------------------------------------
module tb_cnt_seq_monitor;

    localparam int CW = 6;
    localparam int CM = 9;
    localparam int LC = 2;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b1;
    logic [CW-1:0] cnt_in  = '0;
    logic          cnt_vld = 1'b0;
    logic          clear   = 1'b0;

    logic        locked_a, wrap_pulse_a, err_pulse_a;
    logic [15:0] wrap_cnt_a;
    logic [7:0]  err_cnt_a;
    logic        locked_s, wrap_pulse_s, err_pulse_s;
    logic [1:0]  wrap_cnt_s;
    logic [7:0]  err_cnt_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cnt_seq_monitor #(
        .CNT_WIDTH (CW), .CNT_MAX (CM), .LOCK_CNT (LC), .WRAP_WIDTH (16)
    ) dut_a (
        .clk (clk), .rst_n (rst_n), .cnt_in (cnt_in), .cnt_vld (cnt_vld),
        .clear (clear), .locked (locked_a), .wrap_pulse (wrap_pulse_a),
        .wrap_cnt (wrap_cnt_a), .err_pulse (err_pulse_a), .err_cnt (err_cnt_a)
    );

    cnt_seq_monitor #(
        .CNT_WIDTH (CW), .CNT_MAX (CM), .LOCK_CNT (LC), .WRAP_WIDTH (2)
    ) dut_s (
        .clk (clk), .rst_n (rst_n), .cnt_in (cnt_in), .cnt_vld (cnt_vld),
        .clear (clear), .locked (locked_s), .wrap_pulse (wrap_pulse_s),
        .wrap_cnt (wrap_cnt_s), .err_pulse (err_pulse_s), .err_cnt (err_cnt_s)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_anchor = 0;   // have an in-range reference value to step from
    int m_prev   = 0;
    int m_run    = 0;   // consecutive correct steps since the anchor
    int m_wraps  = 0;
    int m_errs   = 0;
    bit m_wp     = 0;
    bit m_ep     = 0;
    int m_v;
    bit m_was_locked, m_hit;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_anchor = 0; m_prev = 0; m_run = 0;
            m_wraps = 0; m_errs = 0; m_wp = 0; m_ep = 0;
        end else if (clear) begin
            m_anchor = 0; m_run = 0; m_wraps = 0; m_errs = 0;
            m_wp = 0; m_ep = 0;
        end else if (cnt_vld) begin
            m_v          = int'(cnt_in);
            m_was_locked = m_anchor && (m_run >= LC);
            m_hit        = m_anchor && (m_v == ((m_prev == CM) ? 0 : m_prev + 1));
            m_wp = m_was_locked && m_hit && (m_prev == CM);
            m_ep = m_was_locked && !m_hit;
            if (m_wp) m_wraps++;
            if (m_ep) m_errs++;
            if (m_hit) begin
                m_run++;
            end else begin
                m_anchor = (m_v <= CM);
                m_run    = 0;
            end
            m_prev = m_v;
        end else begin
            m_wp = 0;
            m_ep = 0;
        end
    end

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic int exp_err_cnt();
`ifdef CNT_SEQ_MON_ERR_CNT_EN
        return sat(m_errs, 255);
`else
        return 0;
`endif
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("m_locked",     int'(locked_a),     int'(m_anchor && (m_run >= LC)));
        chk("m_wrap_pulse", int'(wrap_pulse_a), int'(m_wp));
        chk("m_err_pulse",  int'(err_pulse_a),  int'(m_ep));
        chk("m_wrap_cnt",   int'(wrap_cnt_a),   sat(m_wraps, 65535));
        chk("m_err_cnt",    int'(err_cnt_a),    exp_err_cnt());
        chk("m_s_locked",   int'(locked_s),     int'(m_anchor && (m_run >= LC)));
        chk("m_s_wrap_cnt", int'(wrap_cnt_s),   sat(m_wraps, 3));
        chk("m_s_wpulse",   int'(wrap_pulse_s), int'(m_wp));
    end

    // ---------------- stimulus ----------------
    task automatic step(input int v, input bit clr = 1'b0);
        @(negedge clk);
        cnt_in  = CW'(v);
        cnt_vld = 1'b1;
        clear   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        cnt_vld = 1'b0;
        clear   = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    int npulse;
    int e1;

    initial begin
`ifdef CNT_SEQ_MON_ERR_CNT_EN
        e1 = 1;
`else
        e1 = 0;
`endif
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_locked",     int'(locked_a),     0);
        chk("rst_wrap_pulse", int'(wrap_pulse_a), 0);
        chk("rst_err_pulse",  int'(err_pulse_a),  0);
        chk("rst_wrap_cnt",   int'(wrap_cnt_a),   0);
        chk("rst_err_cnt",    int'(err_cnt_a),    0);

        // Acquire
        step(3); chk("acq_after3", int'(locked_a), 0);
        step(4); chk("acq_after4", int'(locked_a), 0);
        step(5); chk("acq_after5", int'(locked_a), 1);

        // Wrap
        for (int v = 6; v <= 9; v++) step(v);
        step(0);
        chk("wrap_pulse", int'(wrap_pulse_a), 1);
        chk("wrap_cnt1",  int'(wrap_cnt_a),   1);
        step(1);
        chk("wrap_pulse_one", int'(wrap_pulse_a), 0);
        for (int p = 0; p < 4; p++) begin
            for (int v = 2; v <= 9; v++) step(v);
            step(0);
            step(1);
            if (p == 1) chk("wrap_cnt3", int'(wrap_cnt_a), 3);
        end
        chk("wrap_cnt5",     int'(wrap_cnt_a), 5);
        chk("wrap_sat_hold", int'(wrap_cnt_s), 3);

        // Error and relock
        for (int v = 2; v <= 5; v++) step(v);
        step(7);
        chk("err_pulse",  int'(err_pulse_a), 1);
        chk("err_unlock", int'(locked_a),    0);
        chk("err_cnt1",   int'(err_cnt_a),   e1);
        step(8); chk("relock_8", int'(locked_a), 0);
        step(9);
        chk("relock_9",     int'(locked_a),  1);
        chk("err_cnt_keep", int'(err_cnt_a), e1);

        // Out-of-range and gaps
        step(0);
        chk("wrap_before_oor", int'(wrap_pulse_a), 1);
        step(12);
        chk("oor_err_pulse", int'(err_pulse_a), 1);
        chk("oor_unlocked",  int'(locked_a),    0);
        idle(5);
        chk("gap_locked", int'(locked_a),    0);
        chk("gap_pulse",  int'(err_pulse_a), 0);
        step(4); chk("oor_reacq4", int'(locked_a), 0);
        step(5); chk("oor_reacq5", int'(locked_a), 0);
        step(6); chk("oor_reacq6", int'(locked_a), 1);

        // Clear with a same-cycle wrapping sample
        step(7); step(8); step(9);
        step(0, 1'b1);
        chk("clr_no_wrap",  int'(wrap_pulse_a), 0);
        chk("clr_wrap_cnt", int'(wrap_cnt_a),   0);
        chk("clr_err_cnt",  int'(err_cnt_a),    0);
        chk("clr_locked",   int'(locked_a),     0);
        step(1); chk("clr_acq1", int'(locked_a), 0);
        step(2); chk("clr_acq2", int'(locked_a), 0);
        step(3); chk("clr_acq3", int'(locked_a), 1);

        // Asynchronous reset mid-period
        for (int v = 4; v <= 9; v++) step(v);
        step(0);
        chk("pre_rst_wrap_cnt", int'(wrap_cnt_a), 1);
        step(1);
        cnt_vld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_locked",   int'(locked_a),   0);
        chk("arst_wrap_cnt", int'(wrap_cnt_a), 0);
        chk("arst_wpulse",   int'(wrap_pulse_a), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Three errors, first one right behind a wrap
        npulse = 0;
        step(7); step(8); step(9);
        step(0); chk("b2b_wrap", int'(wrap_pulse_a), 1);
        step(5); if (err_pulse_a) npulse++;
        chk("b2b_err", int'(err_pulse_a), 1);
        step(0); step(1); step(2);
        step(0); if (err_pulse_a) npulse++;
        step(1); step(2); step(3);
        step(40); if (err_pulse_a) npulse++;
        chk("err_pulses3", npulse, 3);
`ifdef CNT_SEQ_MON_ERR_CNT_EN
        chk("err_cnt3", int'(err_cnt_a), 3);
`else
        chk("err_cnt_tied", int'(err_cnt_a), 0);
`endif

        step(63);
        chk("oor_top_locked", int'(locked_a), 0);
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
